// File: rtl/vx_l1_mem_sched_pkg.sv
// Shared constants for the L1 memory request scheduler.
// Source index convention: the merged tag MSB names the requesting cache.
package vx_l1_mem_sched_pkg;

  localparam int DEF_DATA_SIZE   = 64;
  localparam int DEF_ADDR_WIDTH  = 26;
  localparam int DEF_TAG_WIDTH   = 8;
  localparam int DEF_MAX_STARVE  = 4;
  localparam int DEF_MAX_PENDING = 16;

  localparam int NUM_REQS = 2;

  localparam logic SRC_ICACHE = 1'b0;
  localparam logic SRC_DCACHE = 1'b1;

endpackage

// File: rtl/vx_l1_mem_sched_ebuf.sv
// Single-entry elastic buffer used as the request output stage.
// Accepts a new entry when empty or when the held entry drains.
module vx_l1_mem_sched_ebuf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out
);

  logic             valid_q, valid_d;
  logic [DATAW-1:0] data_q, data_d;

  // Load on accept, otherwise hold until drained
  always_comb begin
    ready_in = ~valid_q | ready_out;
    valid_d  = valid_q;
    data_d   = data_q;
    if (ready_in) begin
      valid_d = valid_in;
      if (valid_in) data_d = data_in;
    end
  end

  // Occupancy flag, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // Payload needs no reset; it is qualified by valid
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/vx_l1_mem_sched.sv
// Merges icache (0) and dcache (1) requests onto one memory port,
// with starvation relief for dcache and a cap on outstanding reads.
module vx_l1_mem_sched
  import vx_l1_mem_sched_pkg::*;
#(
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int MAX_STARVE  = DEF_MAX_STARVE,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             in_req_valid,
  input  logic [NUM_REQS-1:0]             in_req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]  in_req_addr,
  input  logic [NUM_REQS*DATA_SIZE*8-1:0] in_req_data,
  input  logic [NUM_REQS*DATA_SIZE-1:0]   in_req_byteen,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   in_req_tag,
  output logic [NUM_REQS-1:0]             in_req_ready,
  output logic                            out_req_valid,
  output logic                            out_req_rw,
  output logic [ADDR_WIDTH-1:0]           out_req_addr,
  output logic [DATA_SIZE*8-1:0]          out_req_data,
  output logic [DATA_SIZE-1:0]            out_req_byteen,
  output logic [TAG_WIDTH:0]              out_req_tag,
  input  logic                            out_req_ready,
  input  logic                            out_rsp_valid,
  input  logic [DATA_SIZE*8-1:0]          out_rsp_data,
  input  logic [TAG_WIDTH:0]              out_rsp_tag,
  output logic                            out_rsp_ready,
  output logic [NUM_REQS-1:0]             in_rsp_valid,
  output logic [DATA_SIZE*8-1:0]          in_rsp_data,
  output logic [TAG_WIDTH-1:0]            in_rsp_tag,
  input  logic [NUM_REQS-1:0]             in_rsp_ready,
  output logic                            busy
);

  localparam int DATAW = DATA_SIZE * 8;
  localparam int AW    = ADDR_WIDTH;
  localparam int TW    = TAG_WIDTH;
  localparam int BUFW  = 1 + AW + DATAW + DATA_SIZE + TW + 1;
  localparam int PW    = $clog2(MAX_PENDING + 1);
  localparam int PW1   = PW + 1;
  localparam int SW    = (MAX_STARVE > 1) ? $clog2(MAX_STARVE) : 1;

  localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE - 1);
  localparam logic [PW:0]   PEND_LIM   = PW1'(MAX_PENDING);

  logic [PW-1:0]   pend_cnt_q, pend_cnt_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            buf_ready, buf_valid_in;
  logic [BUFW-1:0] buf_din, buf_dout;
  logic [1:0]      elig, gnt;
  logic [PW:0]     rd_commit;
  logic            rd_full, force1;
  logic            rd_issue, rsp_fire, rsp_src;

  // Reads in flight plus a held read bound new read grants
  always_comb begin
    rd_commit = {1'b0, pend_cnt_q}
              + {{PW{1'b0}}, out_req_valid & ~out_req_rw};
    rd_full = rd_commit >= PEND_LIM;
    elig    = in_req_valid & (in_req_rw | {2{~rd_full}});
    force1  = elig[1] & (starve_cnt_q == STARVE_LIM);
    gnt     = 2'b00;
    if (~reset & buf_ready) begin
      if (elig[1] & (~elig[0] | force1)) gnt = 2'b10;
      else if (elig[0])                  gnt = 2'b01;
    end
    buf_valid_in = |gnt;
    in_req_ready = gnt;
  end

  // Winner's fields; its index becomes the tag MSB
  always_comb begin
    if (gnt[1]) begin
      buf_din = {in_req_rw[1],
                 in_req_addr[2*AW-1:AW],
                 in_req_data[2*DATAW-1:DATAW],
                 in_req_byteen[2*DATA_SIZE-1:DATA_SIZE],
                 SRC_DCACHE,
                 in_req_tag[2*TW-1:TW]};
    end else begin
      buf_din = {in_req_rw[0],
                 in_req_addr[AW-1:0],
                 in_req_data[DATAW-1:0],
                 in_req_byteen[DATA_SIZE-1:0],
                 SRC_ICACHE,
                 in_req_tag[TW-1:0]};
    end
  end

  vx_l1_mem_sched_ebuf #(
    .DATAW (BUFW)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (buf_valid_in),
    .ready_in  (buf_ready),
    .data_in   (buf_din),
    .valid_out (out_req_valid),
    .ready_out (out_req_ready),
    .data_out  (buf_dout)
  );

  assign {out_req_rw, out_req_addr, out_req_data,
          out_req_byteen, out_req_tag} = buf_dout;

  // Responses steer by tag MSB with no buffering
  always_comb begin
    rsp_src         = out_rsp_tag[TW];
    in_rsp_valid[0] = out_rsp_valid & (rsp_src == SRC_ICACHE);
    in_rsp_valid[1] = out_rsp_valid & (rsp_src == SRC_DCACHE);
    out_rsp_ready   = rsp_src ? in_rsp_ready[1] : in_rsp_ready[0];
    in_rsp_data     = out_rsp_data;
    in_rsp_tag      = out_rsp_tag[TW-1:0];
  end

  // Outstanding-read and dcache-starvation bookkeeping
  always_comb begin
    rd_issue   = out_req_valid & out_req_ready & ~out_req_rw;
    rsp_fire   = out_rsp_valid & out_rsp_ready;
    pend_cnt_d = pend_cnt_q;
    unique case (1'b1)
      rd_issue & ~rsp_fire:
        pend_cnt_d = pend_cnt_q + PW'(1);
      ~rd_issue & rsp_fire & (pend_cnt_q != '0):
        pend_cnt_d = pend_cnt_q - PW'(1);
      default: ;
    endcase
    starve_cnt_d = starve_cnt_q;
    if (gnt[1])
      starve_cnt_d = '0;
    else if (in_req_valid[1] & (starve_cnt_q != STARVE_LIM))
      starve_cnt_d = starve_cnt_q + SW'(1);
  end

  // Counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_cnt_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      pend_cnt_q   <= pend_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign busy = out_req_valid | (pend_cnt_q != '0);

endmodule

// File: doc/vx_l1_mem_sched.md
VX_L1_MEM_SCHED -- requirements
Module: VX_l1_mem_sched

Interface
REQ-001 Parameter DATA_SIZE, default 64: line size in bytes; the data width is DATA_SIZE*8.
REQ-002 Parameter ADDR_WIDTH, default 26: line address width.
REQ-003 Parameter TAG_WIDTH, default 8: per-input request tag width.
REQ-004 Parameter MAX_STARVE, default 4: number of consecutive denied cycles after which input 1 is force-granted.
REQ-005 Parameter MAX_PENDING, default 16: maximum number of outstanding read requests.
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- in_req_valid/in_req_rw  input  2 each  per-input request valid / write flag; index 0 is icache, index 1 is dcache.
- in_req_addr  input  2*ADDR_WIDTH  per-input address.
- in_req_data  input  2*DATA_SIZE*8  per-input write data.
- in_req_byteen  input  2*DATA_SIZE  per-input byte enables.
- in_req_tag  input  2*TAG_WIDTH  per-input tag.
- in_req_ready  output  2  per-input accept.
- out_req_valid/out_req_rw  output  1 each  merged request valid / write flag.
- out_req_addr/out_req_data/out_req_byteen  output  ADDR_WIDTH / DATA_SIZE*8 / DATA_SIZE  merged request address, data, byte enables.
- out_req_tag  output  TAG_WIDTH+1  merged tag; MSB is the source index.
- out_req_ready  input  1  downstream accept.
- out_rsp_valid  input  1  response valid.
- out_rsp_data  input  DATA_SIZE*8  response data.
- out_rsp_tag  input  TAG_WIDTH+1  response tag.
- out_rsp_ready  output  1  response accept.
- in_rsp_valid  output  2  per-input response valid.
- in_rsp_data  output  DATA_SIZE*8  shared response data.
- in_rsp_tag  output  TAG_WIDTH  shared response tag.
- in_rsp_ready  input  2  per-input response accept.
- busy  output  1  high while a request is held or any read is outstanding.

Function
REQ-008 Request path: a single output register stage; a grant is taken when the register is empty or drains this cycle (out_req_valid & out_req_ready).
REQ-009 Request latency: a granted request appears on out_req_* the cycle after its in_req_ready/in_req_valid fire, and is held stable until out_req_ready.
REQ-010 Arbitration: fixed priority to input 0; input 1 wins when input 0 is idle, or when starve_cnt == MAX_STARVE-1 and input 1 is valid.
REQ-011 starve_cnt increments each cycle input 1 is valid but not granted, clears when input 1 is granted, and never exceeds MAX_STARVE-1.
REQ-012 pend_cnt, width clog2(MAX_PENDING+1), increments on a read issue (out_req fire with rw=0) and decrements on an out_rsp fire; a simultaneous issue and return leaves it unchanged.
REQ-013 When pend_cnt == MAX_PENDING, read requests are not granted; writes remain grantable and the starvation rules still apply to eligible requests.
REQ-014 Response routing, combinational: in_rsp_valid[out_rsp_tag MSB] = out_rsp_valid; out_rsp_ready = in_rsp_ready[MSB]; in_rsp_tag = out_rsp_tag without the MSB.
REQ-015 At most one in_req_ready bit is high per cycle; an in_req_ready bit is never high unless a grant is possible.

Reset
REQ-016 Under reset: out_req_valid=0, in_req_ready=0, starve_cnt=0, pend_cnt=0, busy=0.
REQ-017 Reset mid-operation: a held request is dropped and outstanding-read accounting is cleared; the system resets the downstream memory in the same cycle.

Structure
REQ-018 The source-index-in-tag-MSB convention and the default constants belong in VX_gpu_pkg.
REQ-019 The output stage is one sub-module instance, VX_elastic_buffer (SIZE=1); the arbiter and counters stay in this module.

Verification
REQ-020 Both inputs valid continuously, out_req_ready=1, MAX_STARVE=4 -> grant pattern 0,0,0,1 repeating; input 1 wins every fourth grant.
REQ-021 Sixteen input-0 reads with no responses -> the 17th read is stalled (in_req_ready[0]=0); an input-1 write is still accepted; one response re-enables reads the next cycle.
REQ-022 Response with tag {1,8'h5A} and in_rsp_ready[1]=0 -> in_rsp_valid=2'b10, in_rsp_tag=8'h5A, out_rsp_ready=0 until in_rsp_ready[1]=1.
REQ-023 out_req_ready held 0 for 5 cycles with a request held -> out_req_* stable, in_req_ready=0; release -> the next grant lands on the following cycle.
REQ-024 Read issue and response in the same cycle with pend_cnt=3 -> pend_cnt stays 3, busy=1.
REQ-025 Assert reset with pend_cnt=7 and a request held -> the next cycle shows out_req_valid=0, pend_cnt=0, busy=0.
